// File: rtl/ms7210_iic_pkg.sv
// Shared types and constants for the MS7210 IIC master.
// The SCL/SDA level helpers give the bus levels for each state and quarter of a bit.
package ms7210_iic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_TX_BYTE,
        ST_RX_ACK,
        ST_RESTART,
        ST_RX_BYTE,
        ST_TX_NACK,
        ST_STOP
    } iic_state_e;

    localparam int   BIT_Q = 4;
    localparam int   WR_Q  = 152;
    localparam int   RD_Q  = 192;
    localparam logic ACK   = 1'b0;
    localparam logic NACK  = 1'b1;

    function automatic logic scl_level(input iic_state_e st, input logic [1:0] qtr);
        logic lvl;
        case (st)
            ST_IDLE:  lvl = 1'b1;
            ST_START: lvl = (qtr != 2'd3);
            ST_STOP:  lvl = (qtr != 2'd0);
            default:  lvl = (qtr == 2'd1) || (qtr == 2'd2);
        endcase
        return lvl;
    endfunction

    // 1 means released (pulled up), 0 means driven low.
    function automatic logic sda_level(input iic_state_e st, input logic [1:0] qtr,
                                       input logic tx_bit);
        logic lvl;
        case (st)
            ST_START, ST_RESTART: lvl = (qtr == 2'd0) || (qtr == 2'd1);
            ST_STOP:              lvl = (qtr == 2'd2) || (qtr == 2'd3);
            ST_TX_BYTE:           lvl = tx_bit;
            ST_TX_NACK:           lvl = NACK;
            default:              lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/ms7210_iic_clk_div.sv
// Quarter-period divider: counts 0..DIV-1 while enabled and flags the last count.
// Held at zero whenever disabled so every transaction starts on a clean quarter.
module ms7210_iic_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/ms7210_iic_master.sv
// Byte-level IIC master for the MS7210: one 16-bit-address write or read per trigger.
// SCL is push-pull, SDA is open-drain through sda_oe; all bus outputs are registered.
module ms7210_iic_master
    import ms7210_iic_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int IIC_FREQ = 400_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  device_id,
    input  logic        iic_trig,
    input  logic        w_r,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic [7:0]  data_out,
    output logic        byte_over,
    output logic        ack_err,
    output logic        scl,
    output logic        sda_out,
    output logic        sda_oe,
    input  logic        sda_in
);

    localparam int         DIV    = CLK_FREQ / (4 * IIC_FREQ);
    localparam logic [1:0] LAST_Q = 2'(BIT_Q - 1);

    iic_state_e  state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  dev_q, dev_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        ack_err_q, ack_err_d;
    logic        byte_over_q, byte_over_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        scl_q, sda_oe_q, sda_out_q;
    logic        sda_lvl_d;
    logic        tick;
    logic [1:0]  byte_nx;
    logic [7:0]  next_tx;

    ms7210_iic_clk_div #(.DIV(DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (busy_q),
        .tick (tick)
    );

    // Byte 3 is only reached through RX_ACK on writes; the read address is loaded by RESTART.
    assign byte_nx = byte_q + 2'd1;
    always_comb begin
        case (byte_nx)
            2'd1:    next_tx = addr_q[15:8];
            2'd2:    next_tx = addr_q[7:0];
            2'd3:    next_tx = wdata_q;
            default: next_tx = dev_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        sh_d        = sh_q;
        rx_d        = rx_q;
        dev_d       = dev_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        ack_err_d   = ack_err_q;
        byte_over_d = 1'b0;
        data_out_d  = data_out_q;

        if (state_q == ST_IDLE) begin
            if (iic_trig) begin
                dev_d     = device_id;
                wr_d      = w_r;
                addr_d    = addr;
                wdata_d   = data_in;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                state_d   = ST_START;
                qtr_d     = '0;
                bit_d     = '0;
                byte_d    = '0;
            end
        end else if (tick) begin
            // Leaving q1 is the entry into q2, where SDA is sampled.
            if (qtr_q == 2'd1) begin
                if (state_q == ST_RX_ACK && sda_in != ACK) ack_err_d = 1'b1;
                if (state_q == ST_RX_BYTE) rx_d = {rx_q[6:0], sda_in};
            end
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == LAST_Q) begin
                case (state_q)
                    ST_START: begin
                        state_d = ST_TX_BYTE;
                        sh_d    = dev_q;
                        bit_d   = '0;
                        byte_d  = '0;
                    end
                    ST_TX_BYTE: begin
                        if (bit_q == 3'd7) begin
                            state_d = ST_RX_ACK;
                        end else begin
                            bit_d = bit_q + 3'd1;
                            sh_d  = {sh_q[6:0], 1'b0};
                        end
                    end
                    ST_RX_ACK: begin
                        if (ack_err_q) begin
                            state_d = ST_STOP;
                        end else if (wr_q && byte_q == 2'd3) begin
                            state_d     = ST_STOP;
                            byte_over_d = 1'b1;
                        end else if (!wr_q && byte_q == 2'd2) begin
                            state_d = ST_RESTART;
                            byte_d  = 2'd3;
                        end else if (!wr_q && byte_q == 2'd3) begin
                            state_d = ST_RX_BYTE;
                            bit_d   = '0;
                        end else begin
                            state_d = ST_TX_BYTE;
                            byte_d  = byte_nx;
                            sh_d    = next_tx;
                            bit_d   = '0;
                        end
                    end
                    ST_RESTART: begin
                        state_d = ST_TX_BYTE;
                        sh_d    = {dev_q[7:1], 1'b1};
                        bit_d   = '0;
                    end
                    ST_RX_BYTE: begin
                        if (bit_q == 3'd7) state_d = ST_TX_NACK;
                        else               bit_d   = bit_q + 3'd1;
                    end
                    ST_TX_NACK: begin
                        state_d     = ST_STOP;
                        byte_over_d = 1'b1;
                        data_out_d  = rx_q;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_lvl_d = sda_level(state_d, qtr_d, sh_d[7]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            qtr_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            sh_q        <= '0;
            rx_q        <= '0;
            dev_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            byte_over_q <= 1'b0;
            data_out_q  <= '0;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            sda_out_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            sh_q        <= sh_d;
            rx_q        <= rx_d;
            dev_q       <= dev_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            ack_err_q   <= ack_err_d;
            byte_over_q <= byte_over_d;
            data_out_q  <= data_out_d;
            scl_q       <= scl_level(state_d, qtr_d);
            sda_oe_q    <= ~sda_lvl_d;
            sda_out_q   <= sda_lvl_d;
        end
    end

    assign busy      = busy_q;
    assign data_out  = data_out_q;
    assign byte_over = byte_over_q;
    assign ack_err   = ack_err_q;
    assign scl       = scl_q;
    assign sda_oe    = sda_oe_q;
    assign sda_out   = sda_out_q;

endmodule

// File: tb/tb_ms7210_iic_master.sv
// Directed bench for ms7210_iic_master with a behavioural IIC slave at device 8'hB2.
// The slave captures every byte the master sends and returns tx_data on reads.
module tb_ms7210_iic_master;
    import ms7210_iic_pkg::*;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  device_id = 8'hB2;
    logic        iic_trig = 1'b0;
    logic        w_r = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  data_in = '0;
    logic        busy, byte_over, ack_err, scl, sda_out, sda_oe, sda_in;
    logic [7:0]  data_out;

    logic        slv_sda = 1'b1;
    logic        bus_sda;

    assign bus_sda = (sda_oe ? sda_out : 1'b1) & slv_sda;
    assign sda_in  = bus_sda;

    always #5 clk = ~clk;

    ms7210_iic_master #(.CLK_FREQ(4_000_000), .IIC_FREQ(100_000)) dut (
        .clk       (clk),
        .rst       (rst),
        .device_id (device_id),
        .iic_trig  (iic_trig),
        .w_r       (w_r),
        .addr      (addr),
        .data_in   (data_in),
        .busy      (busy),
        .data_out  (data_out),
        .byte_over (byte_over),
        .ack_err   (ack_err),
        .scl       (scl),
        .sda_out   (sda_out),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    // slave model state
    int         bitn = 0, fbyte = 0;
    int         ncap = 0, nstart = 0, nstop = 0, nmnack = 0;
    logic [7:0] sr = '0, txsh = '0;
    logic       reading = 1'b0, will_read = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0] cap [64];
    logic       nack_dev = 1'b0;
    logic [7:0] tx_data = 8'h5A;

    always @(scl or bus_sda or rst) begin
        if (rst) begin
            bitn = 0; reading = 1'b0; will_read = 1'b0; slv_sda = 1'b1;
        end else if (scl && !prev_scl) begin
            if (bitn < 8) sr = {sr[6:0], bus_sda};
            else if (bitn == 8 && reading && bus_sda) begin
                nmnack++;
                reading = 1'b0;
            end
            bitn++;
        end else if (!scl && prev_scl) begin
            if (bitn == 8) begin
                if (reading) slv_sda = 1'b1;
                else begin
                    if (ncap < 64) cap[ncap] = sr;
                    ncap++;
                    if (fbyte == 0 && sr[0]) will_read = 1'b1;
                    slv_sda = (nack_dev && fbyte == 0) ? 1'b1 : 1'b0;
                end
                fbyte++;
            end else if (bitn == 9) begin
                bitn = 0;
                slv_sda = 1'b1;
                if (will_read) begin reading = 1'b1; will_read = 1'b0; txsh = tx_data; end
                if (reading) begin slv_sda = txsh[7]; txsh = {txsh[6:0], 1'b0}; end
            end else if (reading && bitn > 0 && bitn < 8) begin
                slv_sda = txsh[7];
                txsh = {txsh[6:0], 1'b0};
            end
        end else if (scl && prev_sda && !bus_sda) begin
            bitn = 0; fbyte = 0; reading = 1'b0; will_read = 1'b0;
            nstart++;
        end else if (scl && !prev_sda && bus_sda) begin
            nstop++;
        end
        prev_scl = scl;
        prev_sda = bus_sda;
    end

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction, sampling on falling clock edges until busy drops.
    task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                           input int retrig_at,
                           output int bcyc, output int bo_n, output int lead,
                           output logic [7:0] dout_bo, output int sda_fall, output logic ae1);
        int bo_at;
        @(negedge clk);
        iic_trig = 1'b1; w_r = w; addr = a; data_in = d;
        @(negedge clk);
        iic_trig = 1'b0;
        ae1 = ack_err;
        bcyc = 0; bo_n = 0; bo_at = 0; dout_bo = '0; sda_fall = -1;
        for (int i = 0; i < 4000 && busy; i++) begin
            bcyc++;
            if (byte_over) begin bo_n++; bo_at = bcyc; dout_bo = data_out; end
            if (sda_fall < 0 && sda_oe) sda_fall = bcyc;
            iic_trig = (bcyc == retrig_at);
            if (bcyc == retrig_at) begin w_r = ~w; addr = ~a; data_in = ~d; end
            @(negedge clk);
        end
        iic_trig = 1'b0;
        lead = (bo_n > 0) ? (bcyc + 1 - bo_at) : -1;
        chk("busy_end", busy, 1'b0);
    endtask

    int         bcyc, bo_n, lead, sda_fall, base, s0, p0, m0;
    logic [7:0] dout_bo;
    logic       ae1;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_byte_over", byte_over, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_scl", scl, 1'b1);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_sda_out", sda_out, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // write 0x1281 <= 0x04
        base = ncap; s0 = nstart; p0 = nstop;
        run_txn(1'b1, 16'h1281, 8'h04, -1, bcyc, bo_n, lead, dout_bo, sda_fall, ae1);
        chk("wr_busy_cycles", bcyc, WR_Q * DIV);
        chk("wr_byte_over_cnt", bo_n, 1);
        chk("wr_byte_over_lead", lead, BIT_Q * DIV);
        chk("wr_start_sda_fall", sda_fall, 21);
        chk("wr_ack_err", ack_err, 1'b0);
        chk("wr_nbytes", ncap - base, 4);
        chk("wr_b0", cap[base], 8'hB2);
        chk("wr_b1", cap[base + 1], 8'h12);
        chk("wr_b2", cap[base + 2], 8'h81);
        chk("wr_b3", cap[base + 3], 8'h04);
        chk("wr_starts", nstart - s0, 1);
        chk("wr_stops", nstop - p0, 1);
        chk("wr_data_out_held", data_out, 8'h00);

        // read 0x0003, slave returns 0x5A
        base = ncap; s0 = nstart; p0 = nstop; m0 = nmnack;
        run_txn(1'b0, 16'h0003, 8'h00, -1, bcyc, bo_n, lead, dout_bo, sda_fall, ae1);
        chk("rd_busy_cycles", bcyc, RD_Q * DIV);
        chk("rd_byte_over_cnt", bo_n, 1);
        chk("rd_byte_over_lead", lead, BIT_Q * DIV);
        chk("rd_data_at_pulse", dout_bo, 8'h5A);
        chk("rd_data_out", data_out, 8'h5A);
        chk("rd_nbytes", ncap - base, 4);
        chk("rd_b0", cap[base], 8'hB2);
        chk("rd_b1", cap[base + 1], 8'h00);
        chk("rd_b2", cap[base + 2], 8'h03);
        chk("rd_b3", cap[base + 3], 8'hB3);
        chk("rd_starts", nstart - s0, 2);
        chk("rd_stops", nstop - p0, 1);
        chk("rd_master_nack", nmnack - m0, 1);
        chk("rd_ack_err", ack_err, 1'b0);

        // slave NACKs the device address
        nack_dev = 1'b1;
        base = ncap; p0 = nstop;
        run_txn(1'b1, 16'h1281, 8'h04, -1, bcyc, bo_n, lead, dout_bo, sda_fall, ae1);
        chk("nack_busy_cycles", bcyc, 440);
        chk("nack_byte_over_cnt", bo_n, 0);
        chk("nack_ack_err", ack_err, 1'b1);
        chk("nack_stops", nstop - p0, 1);
        chk("nack_nbytes", ncap - base, 1);
        chk("nack_data_out_held", data_out, 8'h5A);
        nack_dev = 1'b0;

        // second trigger 100 cycles in is ignored; this trigger also clears ack_err
        base = ncap; s0 = nstart;
        run_txn(1'b1, 16'h2233, 8'h44, 100, bcyc, bo_n, lead, dout_bo, sda_fall, ae1);
        chk("retrig_ack_err_clr", ae1, 1'b0);
        chk("retrig_busy_cycles", bcyc, WR_Q * DIV);
        chk("retrig_byte_over_cnt", bo_n, 1);
        chk("retrig_nbytes", ncap - base, 4);
        chk("retrig_b1", cap[base + 1], 8'h22);
        chk("retrig_b2", cap[base + 2], 8'h33);
        chk("retrig_b3", cap[base + 3], 8'h44);
        chk("retrig_starts", nstart - s0, 1);

        // back-to-back: trigger the cycle after busy fell
        base = ncap;
        run_txn(1'b1, 16'hABCD, 8'h3C, -1, bcyc, bo_n, lead, dout_bo, sda_fall, ae1);
        chk("b2b_busy_cycles", bcyc, WR_Q * DIV);
        chk("b2b_start_sda_fall", sda_fall, 21);
        chk("b2b_b0", cap[base], 8'hB2);
        chk("b2b_b1", cap[base + 1], 8'hAB);
        chk("b2b_b2", cap[base + 2], 8'hCD);
        chk("b2b_b3", cap[base + 3], 8'h3C);
        chk("b2b_data_out_held", data_out, 8'h5A);

        // reset pulse mid-write
        @(negedge clk);
        iic_trig = 1'b1; w_r = 1'b1; addr = 16'h1281; data_in = 8'h04;
        @(negedge clk);
        iic_trig = 1'b0;
        repeat (499) @(negedge clk);
        chk("midrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_scl", scl, 1'b1);
        chk("midrst_sda_oe", sda_oe, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        base = ncap;
        run_txn(1'b1, 16'h1281, 8'h04, -1, bcyc, bo_n, lead, dout_bo, sda_fall, ae1);
        chk("post_rst_busy_cycles", bcyc, WR_Q * DIV);
        chk("post_rst_b3", cap[base + 3], 8'h04);
        chk("post_rst_data_out", data_out, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
